// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a blanking guard at the start of each slot.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    output logic        ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic [2:0]  dbg_state
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_tick_q, frame_tick_d;
    logic          frame_edge;
    logic          hide;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Digit d is suppressed when it and every more significant digit are zero.
    function automatic logic lz_hide(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd3:    return v[15:12] == 4'h0;
            2'd2:    return v[15:8] == 8'h00;
            2'd1:    return v[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Handshake: ready is high while no value is pending; a value is taken on any
    // rising edge with load=1 and ready=1, then held until the next frame boundary.
    assign ready      = ~pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign dbg_state  = {state_q == S_ON, idx_q};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + CW'(1);
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;
        frame_edge   = 1'b0;
        an_d         = 4'b1111;
        seg_d        = 7'b1111111;
        hide         = 1'b0;

        case (state_q)
            S_BLANK: begin
                if (cnt_q == GUARD_LAST) state_d = S_ON;
            end
            default: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d    = S_BLANK;
                    cnt_d      = '0;
                    idx_d      = idx_q + 2'd1;
                    frame_edge = (idx_q == 2'd3);
                end
            end
        endcase

        if (frame_edge) begin
            frame_tick_d = 1'b1;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // A load on the boundary edge itself stays pending for the next frame.
        if (load && ready) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

`ifdef SEG_SCAN_LZ_BLANK_EN
        hide = lz_hide(active_d, idx_d);
`else
        hide = 1'b0;
`endif

        // Outputs follow the next state so they switch on the transition edge.
        if (state_d == S_ON && !hide) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = decode(active_d[idx_d*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'h0000;
            active_q     <= 16'h0000;
            pending_q    <= 1'b0;
            seg_q        <= 7'b1111111;
            an_q         <= 4'b1111;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised scoreboard bench for seg_scan_ctrl; the reference model derives each cycle's
// outputs from the cycle index since reset and a per-frame display value.
module tb_seg_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * SLOT;
    localparam logic [12:0] RST_EXP = {1'b1, 1'b0, 4'b1111, 7'b1111111};
    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic [2:0]  dbg_state;

    seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .ready      (ready),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // scoreboard state
    logic [12:0] exp_q[$];
    int          tag_q[$];
    int          checks = 0;
    int          passes = 0;

    // reference model state
    int          k = 0;
    logic [15:0] disp_val = 16'h0000;
    logic [15:0] pend_val = 16'h0000;
    logic        pend_valid = 1'b0;
    int          pend_frame = 0;

    function automatic logic [12:0] expect_out(input int cyc, input logic [15:0] v, input logic rdy);
        int          phase;
        int          d;
        logic [15:0] sh;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_tick;
        logic        blank_digit;
        phase       = cyc % SLOT;
        d           = (cyc / SLOT) % 4;
        sh          = v >> (4 * d);
        e_an        = 4'b1111;
        e_seg       = 7'b1111111;
        e_tick      = (cyc > 0) && (cyc % FRAME == 0);
        blank_digit = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d > 0 && sh == 16'h0000) blank_digit = 1'b1;
`endif
        if (phase >= GUARD && !blank_digit) begin
            e_an  = ~(4'b0001 << d);
            e_seg = DEC[sh[3:0]];
        end
        return {rdy, e_tick, e_an, e_seg};
    endfunction

    // One clock cycle of stimulus; pushes the expected outputs for that cycle.
    task automatic step(input logic rst, input logic ld, input logic [15:0] val);
        logic rdy;
        @(posedge clk);
        #1;
        rst_n = rst;
        if (!rst) begin
            k          = 0;
            disp_val   = 16'h0000;
            pend_valid = 1'b0;
            load       = 1'b0;
            value      = val;
            exp_q.push_back(RST_EXP);
            tag_q.push_back(-1);
        end else begin
            if (pend_valid && k == pend_frame * FRAME) begin
                disp_val   = pend_val;
                pend_valid = 1'b0;
            end
            rdy = !pend_valid;
            exp_q.push_back(expect_out(k, disp_val, rdy));
            tag_q.push_back(k);
            load  = ld;
            value = val;
            if (ld && rdy) begin
                pend_valid = 1'b1;
                pend_val   = val;
                pend_frame = (k % FRAME == FRAME - 1) ? k / FRAME + 2 : k / FRAME + 1;
            end
            k++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
    endtask

    task automatic wait_model_ready();
        for (int i = 0; i < 4 * FRAME && pend_valid; i++) idle(1);
    endtask

    // monitor: one DUT output sample per cycle, mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [12:0] e;
            logic [12:0] got;
            int          t;
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {ready, frame_tick, an, seg};
            checks++;
            if (got === e) passes++;
            else $display("FAIL out cyc=%0d got rdy=%b tick=%b an=%b seg=%b exp rdy=%b tick=%b an=%b seg=%b",
                          t, got[12], got[11], got[10:7], got[6:0], e[12], e[11], e[10:7], e[6:0]);
        end
    end

    initial begin
        logic [15:0] rv;

        // reset held for three cycles, then release with 1A3F loaded on the first cycle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h1A3F);
        idle(2 * FRAME);

        // second load while not ready must be ignored
        wait_model_ready();
        step(1'b1, 1'b1, 16'h1234);
        idle(3);
        step(1'b1, 1'b1, 16'hFFFF);
        idle(2 * FRAME + 4);

        // load exactly on the boundary edge
        for (int i = 0; i < 4 * FRAME && !(k % FRAME == FRAME - 1 && !pend_valid); i++) idle(1);
        step(1'b1, 1'b1, 16'h9C0E);
        idle(3 * FRAME);

        // leading zeros
        wait_model_ready();
        step(1'b1, 1'b1, 16'h0050);
        idle(2 * FRAME + 4);

        // random traffic
        for (int i = 0; i < 640; i++) begin
            rv = 16'($urandom);
            rv = rv >> (4 * $urandom_range(0, 3));
            step(1'b1, $urandom_range(0, 7) == 0, rv);
        end

        // reset mid-ON of digit 2 with a value pending
        for (int i = 0; i < 4 * FRAME && !(k % FRAME == 1 && !pend_valid); i++) idle(1);
        step(1'b1, 1'b1, 16'hBEEF);
        for (int i = 0; i < 4 * FRAME && (k % FRAME != 2 * SLOT + 4); i++) idle(1);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        idle(FRAME + 8);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain left=%0d required=0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
